// File: rtl/adder_pkg.sv
// Shared state encoding for the sequential arithmetic blocks.
// The one-hot-free binary encoding keeps state registers at two bits.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the per-bit datapath of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit pair per clock, LSB first, through a
// single full adder. Results are published only on entry to DONE.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_c;
  logic             last_bit;
  logic [WIDTH-1:0] sum_cat;

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .cin(cy_q),
    .s  (fa_s),
    .c  (fa_c)
  );

  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  // New sum bit enters at the top; after WIDTH shifts the word is aligned.
  assign sum_cat  = {fa_s, res_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cy_d    = cy_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = SHIFT;
          a_d     = a;
          b_d     = b;
          cy_d    = cin;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_c;
        res_d = sum_cat[WIDTH-1:1];
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          s_d     = sum_cat;
          cout_d  = fa_c;
          // cy_q is the carry into the MSB at this point
          ovf_d   = cy_q ^ fa_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin an addition.
REQ-005 SHALL have port a, input, WIDTH, operand A (unsigned or two's complement).
REQ-006 SHALL have port b, input, WIDTH, operand B.
REQ-007 SHALL have port cin, input, 1, carry-in.
REQ-008 SHALL have port busy, output, 1, high while an addition is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-010 SHALL have port s, output, WIDTH, sum.
REQ-011 SHALL have port cout, output, 1, carry-out of the MSB.
REQ-012 SHALL have port ovf, output, 1, signed overflow flag.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on an accepting edge, SHALL load a, b and cin into internal registers, clear the bit counter, and go to SHIFT.
REQ-015 SHALL ignore start while in SHIFT; the operand registers and the addition in progress SHALL NOT be affected.
REQ-016 In SHIFT, each edge SHALL add the current operand bit pair plus the carry register, LSB first, shift the sum bit into the result register, update the carry register, and increment the counter.
REQ-017 After the WIDTH-th SHIFT edge, SHALL go to DONE; done SHALL be high exactly WIDTH edges after the edge that accepted start.
REQ-018 SHALL hold done high for exactly one cycle; from DONE, SHALL go to IDLE, or to SHIFT if start is high (back-to-back operation, no idle bubble).
REQ-019 s, cout and ovf SHALL update only on the edge entering DONE, and SHALL hold until the next DONE entry; partial sums SHALL NOT be visible on s.
REQ-020 Result SHALL satisfy {cout,s} = a + b + cin, modulo 2^(WIDTH+1).
REQ-021 ovf SHALL equal carry-into-MSB XOR cout.
REQ-022 busy SHALL be high exactly in SHIFT.
REQ-023 Changes on a, b and cin after the accepting edge SHALL NOT affect the result.

Reset
REQ-024 While rst_n is low, SHALL force state to IDLE; counter, carry, operand and result registers to 0; and busy, done, s, cout and ovf to 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the addition with no done pulse; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-026 SHALL place the FSM state encoding constants (IDLE, SHIFT, DONE) in a shared package, adder_pkg, reused by future sequential arithmetic blocks.
REQ-027 SHALL instantiate one combinational sub-module, full_adder (1-bit: a, b, cin -> s, c), for the per-bit add.
REQ-028 The counter width SHALL be derived from WIDTH as clog2(WIDTH+1).

Verification
REQ-029 With WIDTH=4: a=0011, b=0101, cin=0, start pulse -> done pulse 4 edges later; s=1000, cout=0, ovf=1.
REQ-030 With WIDTH=4: a=1111, b=0001, cin=1 -> s=0001, cout=1, ovf=0; busy high for exactly 4 cycles.
REQ-031 Start held high continuously with new operands at each DONE -> back-to-back results every 5 edges, each result correct for the operands captured at its accepting edge.
REQ-032 Start re-pulsed and a/b changed during SHIFT -> result reflects the originally captured operands only.
REQ-033 rst_n pulsed low at the 2nd SHIFT edge -> all outputs 0 immediately with no done pulse; a later start of 0010+0010 -> s=0100.
REQ-034 Exhaustive check for WIDTH=4 over all 512 combinations of a, b and cin -> {cout,s} and ovf match the reference model; repeat a random check at WIDTH=8 and WIDTH=32.
